// File: rtl/enigma_pkg.sv
// Shared constants and types for the Enigma front-panel key path.
package enigma_pkg;

   localparam int KEY_COUNT  = 26;
   localparam int KEY_CODE_W = 5;

   typedef logic [KEY_CODE_W-1:0] key_code_t;

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      GAP
   } sched_state_t;

endpackage : enigma_pkg

// File: rtl/key_edge_pulse.sv
// Two-sample history of one key line; rise is high for one cycle per 0->1 transition.
module key_edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic rise
);

   // hist_reg[1] is the newest sample and hist_reg[0] the one before it.
   logic [1:0] hist_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_reg <= 2'b00;
      end else begin
         hist_reg <= {key_raw, hist_reg[1]};
      end
   end

   assign rise = hist_reg[1] & ~hist_reg[0];

endmodule : key_edge_pulse

// File: rtl/key_event_scheduler.sv
// Turns raw key edges into single key events, arbitrates round-robin and offers
// one code at a time over valid/ready, followed by a rotor settle gap.
module key_event_scheduler
   import enigma_pkg::*;
#(
   parameter int N_KEYS     = KEY_COUNT,
   parameter int CODE_W     = KEY_CODE_W,
   parameter int GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] keys_raw,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              overrun
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [N_KEYS-1:0] rise;

   generate
      for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_edge
         key_edge_pulse u_edge (
            .clk    (clk),
            .reset  (reset),
            .key_raw(keys_raw[gi]),
            .rise   (rise[gi])
         );
      end
   endgenerate

   // Returns {found, index} of the first requester at or after start, wrapping.
   function automatic logic [CODE_W:0] rr_select(input logic [N_KEYS-1:0] req,
                                                 input logic [CODE_W-1:0] start);
      logic [CODE_W:0] res;
      int              idx;
      res = '0;
      for (int k = N_KEYS - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N_KEYS) idx = idx - N_KEYS;
         if (req[idx]) res = {1'b1, CODE_W'(idx)};
      end
      return res;
   endfunction

   sched_state_t      state_reg, state_next;
   logic [N_KEYS-1:0] pending_reg, pending_next;
   logic [N_KEYS-1:0] grant_mask;
   logic [CODE_W-1:0] ptr_reg, ptr_next;
   logic [CODE_W-1:0] code_reg, code_next;
   logic              valid_reg, valid_next;
   logic              overrun_reg, overrun_next;
   logic [GAP_W-1:0]  gap_reg, gap_next;
   logic [CODE_W:0]   sel;
   logic              sel_found;
   logic [CODE_W-1:0] sel_idx;

   assign sel       = rr_select(pending_reg, ptr_reg);
   assign sel_found = sel[CODE_W];
   assign sel_idx   = sel[CODE_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         ptr_reg     <= '0;
         code_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
         gap_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         ptr_reg     <= ptr_next;
         code_reg    <= code_next;
         valid_reg   <= valid_next;
         overrun_reg <= overrun_next;
         gap_reg     <= gap_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg | rise;
      grant_mask   = '0;
      ptr_next     = ptr_reg;
      code_next    = code_reg;
      valid_next   = valid_reg;
      gap_next     = gap_reg;

      case (state_reg)
         IDLE: begin
            if (sel_found) begin
               // A fresh edge on the granted key in this same cycle is a new event.
               pending_next[sel_idx] = rise[sel_idx];
               grant_mask[sel_idx]   = 1'b1;
               code_next             = sel_idx;
               valid_next            = 1'b1;
               ptr_next              = (sel_idx == CODE_W'(N_KEYS - 1)) ? '0 : sel_idx + 1'b1;
               state_next            = OFFER;
            end
         end
         OFFER: begin
            if (key_ready) begin
               valid_next = 1'b0;
               if (GAP_CYCLES > 0) begin
                  gap_next   = GAP_W'(GAP_CYCLES - 1);
                  state_next = GAP;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_reg == '0) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_reg - 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      overrun_next = overrun_reg | (|(rise & pending_reg & ~grant_mask));
   end

   assign key_code  = code_reg;
   assign key_valid = valid_reg;
   assign overrun   = overrun_reg;

endmodule : key_event_scheduler

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: expected codes are queued when keys
// are pressed and popped when the DUT completes a valid/ready transfer.
module tb_key_event_scheduler;

   localparam int N_KEYS = 26;
   localparam int CODE_W = 5;
   localparam int GAP_CYCLES = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N_KEYS-1:0] keys_raw = '0;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready = 1'b0;
   logic              overrun;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_xfer = 0;
   int exp_q[$];
   int xfer_cyc_q[$];

   key_event_scheduler #(
      .N_KEYS(N_KEYS), .CODE_W(CODE_W), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .keys_raw(keys_raw), .key_code(key_code),
      .key_valid(key_valid), .key_ready(key_ready), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Transfers are sampled on the falling edge; the handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (!reset && key_valid && key_ready) begin
         n_xfer++;
         xfer_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("extra_key", 32'(key_code), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("key_code", 32'(key_code), 32'(e));
            $display("xfer: cycle %0d code %0d expected %0d", cyc, key_code, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key_ready = 1'b0;
      tick();
      check("rst_valid", 32'(key_valid), 0);
      check("rst_code", 32'(key_code), 0);
      check("rst_overrun", 32'(overrun), 0);
      exp_q.delete();
      xfer_cyc_q.delete();
      n_xfer = 0;
      reset = 1'b0;
   endtask

   task automatic wait_valid(output int at_cyc);
      int budget;
      budget = 200;
      while (!key_valid && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("valid_timeout", 0, 1);
      at_cyc = cyc;
   endtask

   task automatic wait_drain();
      int budget;
      budget = 300;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      check("drain_left", 32'(exp_q.size()), 0);
   endtask

   initial begin
      int t0, tv, bad;
      tick();
      do_reset();

      // Single press with latency and single-event checks.
      key_ready = 1'b1;
      ticks(3);
      exp_q.push_back(3);
      t0 = cyc;
      keys_raw[3] = 1'b1;
      wait_valid(tv);
      check("latency", 32'(tv - (t0 + 1)), 2);
      check("single_code", 32'(key_code), 3);
      tick();
      check("valid_one_cycle", 32'(key_valid), 0);
      ticks(30);
      check("single_count", 32'(n_xfer), 1);
      wait_drain();
      keys_raw = '0;
      ticks(2);

      // Simultaneous press from ptr 0.
      do_reset();
      key_ready = 1'b1;
      exp_q.push_back(2); exp_q.push_back(7); exp_q.push_back(20);
      keys_raw[2] = 1'b1; keys_raw[7] = 1'b1; keys_raw[20] = 1'b1;
      wait_drain();
      check("simul_count", 32'(n_xfer), 3);
      if (xfer_cyc_q.size() == 3) begin
         check("spacing_a", 32'(xfer_cyc_q[1] - xfer_cyc_q[0]), 32'(2 + GAP_CYCLES));
         check("spacing_b", 32'(xfer_cyc_q[2] - xfer_cyc_q[1]), 32'(2 + GAP_CYCLES));
      end
      keys_raw = '0;

      // Round-robin wrap after granting the last key.
      do_reset();
      exp_q.push_back(25); exp_q.push_back(0); exp_q.push_back(24);
      keys_raw[25] = 1'b1;
      wait_valid(tv);
      keys_raw[24] = 1'b1; keys_raw[0] = 1'b1;
      ticks(4);
      key_ready = 1'b1;
      wait_drain();
      check("wrap_count", 32'(n_xfer), 3);
      keys_raw = '0;

      // Backpressure: offered code must hold until ready.
      do_reset();
      exp_q.push_back(5);
      keys_raw[5] = 1'b1;
      wait_valid(tv);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!key_valid || key_code != 5) bad++;
      end
      check("hold_unstable", 32'(bad), 0);
      key_ready = 1'b1;
      tick();
      check("accept_first_ready", 32'(key_valid), 0);
      wait_drain();
      keys_raw = '0;

      // Overrun: re-press of a still-pending key.
      do_reset();
      exp_q.push_back(1); exp_q.push_back(9);
      keys_raw[1] = 1'b1;
      wait_valid(tv);
      keys_raw[9] = 1'b1; ticks(2);
      check("no_overrun_yet", 32'(overrun), 0);
      keys_raw[9] = 1'b0; ticks(2);
      keys_raw[9] = 1'b1; ticks(3);
      check("overrun_set", 32'(overrun), 1);
      key_ready = 1'b1;
      wait_drain();
      ticks(20);
      check("overrun_count", 32'(n_xfer), 2);
      check("overrun_sticky", 32'(overrun), 1);
      keys_raw = '0;

      // Reset while offering with keys pending; key 4 held through reset.
      do_reset();
      keys_raw[0] = 1'b1;
      wait_valid(tv);
      keys_raw[1] = 1'b1; keys_raw[4] = 1'b1; ticks(3);
      keys_raw[1] = 1'b0; ticks(2);
      keys_raw[1] = 1'b1; ticks(2);
      check("pre_rst_overrun", 32'(overrun), 1);
      keys_raw = '0;
      keys_raw[4] = 1'b1;
      do_reset();
      exp_q.push_back(4);
      key_ready = 1'b1;
      wait_drain();
      ticks(20);
      check("post_rst_count", 32'(n_xfer), 1);
      check("post_rst_overrun", 32'(overrun), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_key_event_scheduler
